// File: rtl/myproject_sdiv_13s_3ns_13_seq.sv
// Sequential signed/unsigned restoring divider: 13-bit signed dividend, 3-bit unsigned divisor, one quotient bit per clock.
// Optional macro MYPROJECT_SDIV_REM_EN enables the signed remainder output; without it rem is tied to 0.
module myproject_sdiv_13s_3ns_13_seq #(
    parameter int ID         = 1,
    parameter int din0_WIDTH = 13,
    parameter int din1_WIDTH = 3,
    parameter int dout_WIDTH = 13
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [dout_WIDTH-1:0] dout,
    output logic [din1_WIDTH:0]   rem,
    output logic                  div_by_zero
);

    localparam int            CW        = 4;
    localparam logic [CW-1:0] LAST_STEP = CW'(din0_WIDTH);
    localparam logic [dout_WIDTH-1:0] Q_MAX = {1'b0, {(dout_WIDTH-1){1'b1}}};
    localparam logic [dout_WIDTH-1:0] Q_MIN = {1'b1, {(dout_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t                  r_state;
    logic                    r_in_ready;
    logic                    r_out_valid;
    logic [CW-1:0]           r_cnt;
    logic [din0_WIDTH-1:0]   r_work;      // dividend magnitude shifting out, quotient bits shifting in
    logic [din1_WIDTH-1:0]   r_part;
    logic [din1_WIDTH-1:0]   r_divisor;
    logic                    r_neg;
    logic [dout_WIDTH-1:0]   r_dout;
    logic                    r_dbz;

    logic [din0_WIDTH-1:0]   w_abs;
    logic [din1_WIDTH:0]     w_trial;
    logic                    w_fits;
    logic [din1_WIDTH-1:0]   w_diff;
    logic                    w_zero;
    logic [dout_WIDTH-1:0]   w_quo;

    // Two's-complement negate; -4096 maps to magnitude 4096, still representable unsigned.
    assign w_abs   = din0[din0_WIDTH-1] ? (~din0 + 1'b1) : din0;
    assign w_trial = {r_part, r_work[din0_WIDTH-1]};
    assign w_fits  = (w_trial >= {1'b0, r_divisor});
    assign w_diff  = w_trial[din1_WIDTH-1:0] - r_divisor;
    assign w_zero  = (r_divisor == '0);
    assign w_quo   = dout_WIDTH'(r_neg ? (~r_work + 1'b1) : r_work);

`ifdef MYPROJECT_SDIV_REM_EN
    logic [din1_WIDTH:0] r_rem;
    logic [din1_WIDTH:0] w_rem;

    // Remainder takes the dividend's sign so that din0 == dout*din1 + rem.
    assign w_rem = r_neg ? (~{1'b0, r_part} + 1'b1) : {1'b0, r_part};
    assign rem   = r_rem;
`else
    assign rem   = '0;
`endif

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign dout        = r_dout;
    assign div_by_zero = r_dbz;

    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_cnt       <= '0;
            r_work      <= '0;
            r_part      <= '0;
            r_divisor   <= '0;
            r_neg       <= 1'b0;
            r_dout      <= '0;
            r_dbz       <= 1'b0;
`ifdef MYPROJECT_SDIV_REM_EN
            r_rem       <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_work     <= w_abs;
                        r_divisor  <= din1;
                        r_neg      <= din0[din0_WIDTH-1];
                        r_part     <= '0;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (r_cnt != LAST_STEP) begin
                        r_work <= {r_work[din0_WIDTH-2:0], w_fits};
                        r_part <= w_fits ? w_diff : w_trial[din1_WIDTH-1:0];
                        r_cnt  <= r_cnt + CW'(1);
                    end else begin
                        // Divide-by-zero still walks all steps so latency stays constant; result is saturated here.
                        r_dbz       <= w_zero;
                        r_dout      <= w_zero ? (r_neg ? Q_MIN : Q_MAX) : w_quo;
`ifdef MYPROJECT_SDIV_REM_EN
                        r_rem       <= w_zero ? '0 : w_rem;
`endif
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_myproject_sdiv_13s_3ns_13_seq.sv
// Directed self-checking bench for myproject_sdiv_13s_3ns_13_seq; remainder expectations follow MYPROJECT_SDIV_REM_EN.
module tb_myproject_sdiv_13s_3ns_13_seq;

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic        in_valid;
    logic        in_ready;
    logic [12:0] din0;
    logic [2:0]  din1;
    logic        out_valid;
    logic        out_ready;
    logic [12:0] dout;
    logic [3:0]  rem;
    logic        div_by_zero;

    int n_checks = 0;
    int n_errors = 0;

    myproject_sdiv_13s_3ns_13_seq dut (
        .ap_clk      (ap_clk),
        .ap_rst      (ap_rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .din0        (din0),
        .din1        (din1),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .dout        (dout),
        .rem         (rem),
        .div_by_zero (div_by_zero)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int exp_rem(input int r);
`ifdef MYPROJECT_SDIV_REM_EN
        return r;
`else
        return 0;
`endif
    endfunction

    // Issue one operation, measure latency, check result, then release it with a one-cycle out_ready.
    task automatic run_div(input string tag, input int a, input int b,
                           input int eq, input int er, input int edz, input bit keep_valid);
        int lat;
        @(negedge ap_clk);
        check({tag, ":in_ready"}, int'(in_ready), 1);
        din0     = a[12:0];
        din1     = b[2:0];
        in_valid = 1'b1;
        @(posedge ap_clk);
        #1;
        in_valid = keep_valid;
        din0     = ~din0;
        din1     = din1 ^ 3'b101;
        lat = 0;
        while (lat < 40) begin
            @(posedge ap_clk);
            lat++;
            #1;
            if (out_valid) break;
        end
        in_valid = 1'b0;
        check({tag, ":latency"}, lat, 14);
        check({tag, ":dout"}, int'($signed(dout)), eq);
        check({tag, ":rem"}, int'($signed(rem)), exp_rem(er));
        check({tag, ":dbz"}, int'(div_by_zero), edz);
        @(negedge ap_clk);
        out_ready = 1'b1;
        @(posedge ap_clk);
        #1;
        out_ready = 1'b0;
        check({tag, ":released"}, int'(out_valid), 0);
    endtask

    initial begin
        int seen;
        ap_rst    = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        din0      = '0;
        din1      = '0;
        #12;
        check("rst:in_ready", int'(in_ready), 1);
        check("rst:out_valid", int'(out_valid), 0);
        check("rst:dout", int'(dout), 0);
        check("rst:rem", int'(rem), 0);
        check("rst:dbz", int'(div_by_zero), 0);
        @(negedge ap_clk);
        ap_rst = 1'b0;

        run_div("100/7",    100,   7,    14,  2, 0, 1'b0);
        run_div("-100/7",  -100,   7,   -14, -2, 0, 1'b1);
        run_div("-4096/1", -4096,  1, -4096,  0, 0, 1'b0);
        run_div("4095/7",   4095,  7,   585,  0, 0, 1'b0);
        run_div("5/0",         5,  0,  4095,  0, 1, 1'b0);
        run_div("-5/0",       -5,  0, -4096,  0, 1, 1'b0);
        run_div("6/7",         6,  7,     0,  6, 0, 1'b0);
        run_div("-13/5",     -13,  5,    -2, -3, 0, 1'b0);

        // Backpressure: result must hold for 10 cycles, new operands ignored while DONE.
        @(negedge ap_clk);
        din0 = 13'd1000; din1 = 3'd3; in_valid = 1'b1;
        @(posedge ap_clk);
        #1;
        in_valid = 1'b0;
        seen = 0;
        while (seen < 40 && !out_valid) begin
            @(posedge ap_clk);
            seen++;
            #1;
        end
        check("hold:latency", seen, 14);
        din0 = 13'd77; din1 = 3'd2; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge ap_clk);
            check("hold:out_valid", int'(out_valid), 1);
            check("hold:dout", int'($signed(dout)), 333);
            check("hold:rem", int'($signed(rem)), exp_rem(1));
            check("hold:in_ready", int'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(posedge ap_clk);
        #1;
        check("hold:drop", int'(out_valid), 0);
        check("hold:no_same_edge_accept", int'(in_ready), 1);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge ap_clk);
            if (out_valid) seen++;
        end
        check("hold:single_transfer", seen, 0);

        // Reset during CALC step 6: outputs clear at once, aborted op never completes.
        @(negedge ap_clk);
        din0 = 13'd200; din1 = 3'd3; in_valid = 1'b1;
        @(posedge ap_clk);
        #1;
        in_valid = 1'b0;
        repeat (6) @(posedge ap_clk);
        #2;
        ap_rst = 1'b1;
        #1;
        check("midrst:in_ready", int'(in_ready), 1);
        check("midrst:out_valid", int'(out_valid), 0);
        check("midrst:dout", int'(dout), 0);
        check("midrst:rem", int'(rem), 0);
        check("midrst:dbz", int'(div_by_zero), 0);
        @(negedge ap_clk);
        ap_rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge ap_clk);
            if (out_valid) seen++;
        end
        check("midrst:no_result", seen, 0);

        run_div("post_rst 13/4", 13, 4, 3, 1, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/myproject_sdiv_13s_3ns_13_seq.md
MYPROJECT_SDIV_13S_3NS_13_SEQ -- requirements
Module: myproject_sdiv_13s_3ns_13_seq

Interface
REQ-001 SHALL have parameter ID, default 1, instance identifier with no functional effect.
REQ-002 SHALL have parameter din0_WIDTH, default 13, signed dividend width.
REQ-003 SHALL have parameter din1_WIDTH, default 3, unsigned divisor width.
REQ-004 SHALL have parameter dout_WIDTH, default 13, signed quotient width (equal to din0_WIDTH).
REQ-005 SHALL have port ap_clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port ap_rst, input, 1 bit, asynchronous active-high reset.
REQ-007 SHALL have port in_valid, input, 1 bit, operands valid.
REQ-008 SHALL have port in_ready, output, 1 bit, block can accept operands.
REQ-009 SHALL have port din0, input, din0_WIDTH bits, signed dividend.
REQ-010 SHALL have port din1, input, din1_WIDTH bits, unsigned divisor.
REQ-011 SHALL have port out_valid, output, 1 bit, result valid.
REQ-012 SHALL have port out_ready, input, 1 bit, consumer accepts result.
REQ-013 SHALL have port dout, output, dout_WIDTH bits, signed quotient.
REQ-014 SHALL have port rem, output, din1_WIDTH+1 bits, signed remainder.
REQ-015 SHALL have port div_by_zero, output, 1 bit, divisor was zero, qualified by out_valid.

Function
REQ-016 SHALL implement an FSM with states IDLE, CALC and DONE; in_ready SHALL be 1 only in IDLE.
REQ-017 SHALL accept operands on an edge where in_valid and in_ready are both 1: register |din0|, din1 and the dividend sign, clear the 4-bit step counter, go to CALC.
REQ-018 SHALL, in CALC, perform one restoring-division step per edge (shift partial remainder, compare to divisor, subtract, set quotient bit), MSB first, for exactly 13 steps.
REQ-019 SHALL, on the edge after the 13th step, apply sign correction (quotient negated if dividend negative), register dout, rem and div_by_zero, enter DONE, and assert out_valid.
REQ-020 SHALL use constant latency: operands accepted at edge N give out_valid high from edge N+14, including the divide-by-zero case.
REQ-021 SHALL implement truncating division: quotient rounds toward zero; remainder carries the sign of the dividend; |rem| < din1.
REQ-022 SHALL handle dividend -4096 through a 13-bit unsigned magnitude; -4096/1 SHALL yield -4096 with no overflow.
REQ-023 SHALL, when din1 = 0, set div_by_zero=1, dout=4095 for a non-negative dividend and -4096 for a negative one, and rem=0.
REQ-024 SHALL hold dout, rem, div_by_zero and out_valid stable in DONE until out_ready=1; on that edge out_valid SHALL fall and the FSM SHALL return to IDLE. No new operand SHALL be accepted on the same edge.
REQ-025 SHALL ignore in_valid outside IDLE, and din0/din1 changes after acceptance.

Reset
REQ-026 SHALL, on ap_rst=1 at any time, including mid-CALC, immediately force state IDLE, in_ready=1, out_valid=0, dout=0, rem=0, div_by_zero=0, counter=0.
REQ-027 SHALL discard any in-flight operation on reset and emit no result for it.

Configuration
REQ-028 SHALL support macro MYPROJECT_SDIV_REM_EN. When defined, rem carries the signed remainder per REQ-021. When undefined, rem SHALL be constant 0, and remainder sign-correction and output registers SHALL be omitted. Quotient, latency and handshake SHALL be identical in both builds.

Verification
REQ-029 SHALL cover din0=100, din1=7 -> dout=14, rem=2, div_by_zero=0, out_valid at acceptance+14.
REQ-030 SHALL cover din0=-100, din1=7 -> dout=-14, rem=-2 (rem=0 without MYPROJECT_SDIV_REM_EN).
REQ-031 SHALL cover din0=-4096, din1=1 -> dout=-4096, rem=0, and din0=4095, din1=7 -> dout=585, rem=0.
REQ-032 SHALL cover din0=5, din1=0 -> dout=4095, div_by_zero=1, and din0=-5, din1=0 -> dout=-4096, div_by_zero=1.
REQ-033 SHALL cover out_ready held 0 for 10 cycles after out_valid -> outputs stable, in_ready=0, and a single result transfer when out_ready rises.
REQ-034 SHALL cover ap_rst pulsed at CALC step 6 -> all outputs at reset values immediately, and no out_valid for the aborted operation.
